sr_64b_pipe: RTL and testbench

Pipelined 64-bit right shifter: logical (SRL) and arithmetic (SRA), with rotate-right (ROR) as a build option. It is the right-shift counterpart of the left shifter in the same arithmetic library. It is intended for ALU/datapath use where a valid/ready stream replaces the single-shot `init_i`/`done_o` flow. The shift is split into three 2-bit stages, and downstream back-pressure stalls the whole pipeline.

---
 rtl/sr_64b_pipe_if.sv | 21 ++
 rtl/sr_64b_pipe.sv | 121 ++++++++++++
 tb/tb_sr_64b_pipe.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sr_64b_pipe_if.sv
// Stream interface for sr_64b_pipe: operand/valid/ready in, result/valid/ready out.
interface sr_64b_pipe_if;
  logic        init_i;
  logic        ready_o;
  logic [1:0]  op_i;
  logic [5:0]  shift_i;
  logic [63:0] data_i;
  logic        done_o;
  logic        ready_i;
  logic [63:0] data_o;

  modport master (
    output init_i, op_i, shift_i, data_i, ready_i,
    input  ready_o, done_o, data_o
  );

  modport slave (
    input  init_i, op_i, shift_i, data_i, ready_i,
    output ready_o, done_o, data_o
  );
endinterface

// File: rtl/sr_64b_pipe.sv
// Three-stage 64-bit right shifter (SRL/SRA, ROR when SR_64B_PIPE_ROTATE_EN is defined)
// with a global stall on downstream back-pressure and an optional output register.
module sr_64b_pipe #(
  parameter int OUT_REG = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sr_64b_pipe_if.slave  bus
);

  // Shift d right by amt; the upper half of the 128-bit window supplies the fill bits.
  function automatic logic [63:0] shr_stage(input logic [63:0] d, input logic [5:0] amt,
                                            input logic sra, input logic ror, input logic sign);
    logic [63:0]  fill;
    logic [127:0] wide;
    fill = ror ? d : {64{sra & sign}};
    wide = {fill, d} >> amt;
    return wide[63:0];
  endfunction

  logic stall;
  logic accept;
  logic ror_in;
  logic sra_in;

`ifdef SR_64B_PIPE_ROTATE_EN
  assign ror_in = bus.op_i[1];
`else
  logic unused_op1;
  assign unused_op1 = bus.op_i[1];
  assign ror_in     = 1'b0;
`endif
  assign sra_in = bus.op_i[0] & ~ror_in;

  logic        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [63:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic        sra1_q, sra1_d, sra2_q, sra2_d;
  logic        ror1_q, ror1_d, ror2_q, ror2_d;
  logic        sgn1_q, sgn1_d, sgn2_q, sgn2_d;
  logic [3:0]  sh1_q, sh1_d;
  logic [1:0]  sh2_q, sh2_d;

  assign stall       = bus.done_o & ~bus.ready_i;
  assign bus.ready_o = ~stall;
  assign accept      = bus.init_i & ~stall;

  always_comb begin
    v1_d   = accept;
    d1_d   = shr_stage(bus.data_i, {4'b0000, bus.shift_i[1:0]}, sra_in, ror_in, bus.data_i[63]);
    sra1_d = sra_in;
    ror1_d = ror_in;
    sgn1_d = bus.data_i[63];
    sh1_d  = bus.shift_i[5:2];

    v2_d   = v1_q;
    d2_d   = shr_stage(d1_q, {2'b00, sh1_q[1:0], 2'b00}, sra1_q, ror1_q, sgn1_q);
    sra2_d = sra1_q;
    ror2_d = ror1_q;
    sgn2_d = sgn1_q;
    sh2_d  = sh1_q[3:2];

    v3_d   = v2_q;
    d3_d   = shr_stage(d2_q, {sh2_q, 4'b0000}, sra2_q, ror2_q, sgn2_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q   <= 1'b0;
      d1_q   <= '0;
      sra1_q <= 1'b0;
      ror1_q <= 1'b0;
      sgn1_q <= 1'b0;
      sh1_q  <= '0;
      v2_q   <= 1'b0;
      d2_q   <= '0;
      sra2_q <= 1'b0;
      ror2_q <= 1'b0;
      sgn2_q <= 1'b0;
      sh2_q  <= '0;
      v3_q   <= 1'b0;
      d3_q   <= '0;
    end else if (!stall) begin
      v1_q   <= v1_d;
      d1_q   <= d1_d;
      sra1_q <= sra1_d;
      ror1_q <= ror1_d;
      sgn1_q <= sgn1_d;
      sh1_q  <= sh1_d;
      v2_q   <= v2_d;
      d2_q   <= d2_d;
      sra2_q <= sra2_d;
      ror2_q <= ror2_d;
      sgn2_q <= sgn2_d;
      sh2_q  <= sh2_d;
      v3_q   <= v3_d;
      d3_q   <= d3_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic        vo_q;
      logic [63:0] do_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          vo_q <= 1'b0;
          do_q <= '0;
        end else if (!stall) begin
          vo_q <= v3_q;
          do_q <= d3_q;
        end
      end
      assign bus.done_o = vo_q;
      assign bus.data_o = do_q;
    end else begin : g_no_out_reg
      assign bus.done_o = v3_q;
      assign bus.data_o = d3_q;
    end
  endgenerate

endmodule

// File: tb/tb_sr_64b_pipe.sv
// Randomised and directed bench for sr_64b_pipe against a queue-based reference model.
module tb_sr_64b_pipe;
  localparam int OUT_REG = 1;
  localparam int LAT     = 3 + OUT_REG;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_64b_pipe_if bus ();

  sr_64b_pipe #(.OUT_REG(OUT_REG)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [63:0] exp_q[$];
  int          acc_q[$];
  int          stl_q[$];
  int          cyc     = 0;
  int          stalls  = 0;
  int          checks  = 0;
  int          errors  = 0;
  bit          chk_zero = 1'b0;

  task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_shift(input logic [1:0] op, input logic [5:0] s,
                                            input logic [63:0] d);
    int unsigned       n;
    logic signed [63:0] sd;
    n  = s;
    sd = d;
`ifdef SR_64B_PIPE_ROTATE_EN
    if (op[1]) return (n == 0) ? d : ((d >> n) | (d << (64 - n)));
`endif
    if (op[0]) return sd >>> n;
    return d >> n;
  endfunction

  // One clock cycle: drive, check outputs against the model, update model, advance.
  task automatic cycle(input logic init, input logic [1:0] op, input logic [5:0] sh,
                       input logic [63:0] d, input logic rdy, input logic rs,
                       output bit acc);
    bit exp_done;
    bit stall;
    bus.init_i  = init;
    bus.op_i    = op;
    bus.shift_i = sh;
    bus.data_i  = d;
    bus.ready_i = rdy;
    rst         = rs;
    #1;
    exp_done = (exp_q.size() > 0) && ((cyc - acc_q[0] - (stalls - stl_q[0])) >= LAT);
    check64("done_o", {63'b0, bus.done_o}, {63'b0, exp_done});
    if (exp_done) check64("data_o", bus.data_o, exp_q[0]);
    if (chk_zero) check64("data_o_after_reset", bus.data_o, 64'h0);
    stall = exp_done && !rdy;
    check64("ready_o", {63'b0, bus.ready_o}, {63'b0, !stall});
    acc = 1'b0;
    if (rs) begin
      exp_q.delete();
      acc_q.delete();
      stl_q.delete();
    end else begin
      if (exp_done && rdy) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        void'(stl_q.pop_front());
      end
      if (stall) stalls++;
      if (init && !stall) begin
        acc = 1'b1;
        exp_q.push_back(ref_shift(op, sh, d));
        acc_q.push_back(cyc);
        stl_q.push_back(stalls);
      end
    end
    chk_zero = rs;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 6'd0, 64'h0, 1'b1, 1'b0, a);
  endtask

  task automatic push1(input logic [1:0] op, input logic [5:0] sh, input logic [63:0] d);
    bit a;
    cycle(1'b1, op, sh, d, 1'b1, 1'b0, a);
  endtask

  initial begin
    bit a;
    int k;
    int t;
    bus.init_i  = 1'b0;
    bus.op_i    = 2'b00;
    bus.shift_i = 6'd0;
    bus.data_i  = 64'h0;
    bus.ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // reset held with an input presented: must be dropped
    cycle(1'b1, 2'b01, 6'd5, 64'hDEAD_BEEF_0000_1234, 1'b1, 1'b1, a);
    cycle(1'b1, 2'b00, 6'd3, 64'h1234, 1'b1, 1'b1, a);
    idle(LAT + 2);

    for (int i = 0; i < 64; i++) push1(2'b00, 6'(i), 64'hFFFF_FFFF_FFFF_FFFF);
    idle(LAT + 2);

    push1(2'b01, 6'd63, 64'h8000_0000_0000_0000);
    push1(2'b01, 6'd4,  64'h8000_0000_0000_0000);
    push1(2'b01, 6'd63, 64'h7FFF_FFFF_FFFF_FFFF);
    push1(2'b01, 6'd0,  64'h8000_0000_0000_0001);
    push1(2'b10, 6'd4,  64'h0000_0000_0000_00F0);
    push1(2'b11, 6'd0,  64'hA5A5_0000_FFFF_1234);
    idle(LAT + 2);

    for (int i = 0; i < 64; i++) push1(2'b00, 6'(i), 64'h1);
    push1(2'b10, 6'd1,  64'h1);
    push1(2'b10, 6'd63, 64'h1);
    push1(2'b11, 6'd17, 64'h8000_0000_0000_0001);
    idle(LAT + 2);

    // back-pressure mid-stream
    k = 0;
    t = 0;
    while ((k < 8 || exp_q.size() > 0) && t < 60) begin
      cycle(k < 8, 2'(k % 4), 6'(k * 7 + 1), 64'hF00D_0000_0000_0000 | 64'(k),
            !(t >= 6 && t < 11), 1'b0, a);
      if (a) k++;
      t++;
    end
    check64("bp_all_drained", {32'b0, 32'(exp_q.size())}, 64'h0);
    check64("bp_all_accepted", 64'(k), 64'd8);

    // reset with three items in flight, then confirm no stale results
    push1(2'b01, 6'd9,  64'h8123_4567_89AB_CDEF);
    push1(2'b00, 6'd33, 64'hFFFF_0000_FFFF_0000);
    push1(2'b10, 6'd40, 64'h0123_4567_89AB_CDEF);
    cycle(1'b1, 2'b00, 6'd1, 64'h5555, 1'b1, 1'b1, a);
    idle(LAT + 3);

    for (int i = 0; i < 400; i++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) d = {64{d[63]}} ^ (64'h1 << $urandom_range(0, 63));
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
            d, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, a);
    end
    idle(LAT + 2);
    check64("final_drained", {32'b0, 32'(exp_q.size())}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
